// File: rtl/sparse_mac_nway.sv
// N-way sparse dot-product engine.
// Decodes NUM_STREAMS run-length-compressed streams into absolute indices,
// intersects them, multiplies the values found at common indices and
// accumulates them (saturating or wrapping). The result, an overflow flag
// and the match count are returned on a valid/ready port.
module sparse_mac_nway #(
    parameter int NUM_STREAMS = 2,
    parameter int VALUE_W     = 8,
    parameter int SKIP_W      = 8,
    parameter int IDX_W       = 16,
    parameter int ACCUM_W     = 32,
    parameter int SATURATE    = 1
) (
    input  logic                           mac_clk,
    input  logic                           mac_rst,
    input  logic [NUM_STREAMS-1:0]         sram_valid_i,
    output logic [NUM_STREAMS-1:0]         sram_ready_o,
    input  logic [NUM_STREAMS-1:0]         sram_done_i,
    input  logic [NUM_STREAMS*SKIP_W-1:0]  sram_skip_i,
    input  logic [NUM_STREAMS*VALUE_W-1:0] sram_value_i,
    output logic                           mac_valid_o,
    input  logic                           mac_ready_i,
    output logic [ACCUM_W-1:0]             mac_data_o,
    output logic                           mac_ovf_o,
    output logic [IDX_W-1:0]               mac_match_cnt_o
);

    localparam int PROD_W = VALUE_W * NUM_STREAMS;
    localparam int SUM_W  = ((PROD_W > ACCUM_W) ? PROD_W : ACCUM_W) + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Per-stream head registers. head_idx_q also serves as the previous
    // decoded index, since it always holds the last accepted value token.
    logic [NUM_STREAMS-1:0]              head_v_q;
    logic [NUM_STREAMS-1:0]              head_done_q;
    logic [NUM_STREAMS-1:0]              first_q;
    logic [NUM_STREAMS-1:0][IDX_W-1:0]   head_idx_q;
    logic [NUM_STREAMS-1:0][VALUE_W-1:0] head_val_q;

    // Product stage
    logic              vld_p1_q;
    logic [PROD_W-1:0] prod_p1_q;
    logic [PROD_W-1:0] prod_c;

    // Accumulation state
    logic [ACCUM_W-1:0] accum_q, accum_d;
    logic               ovf_q, ovf_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [ACCUM_W:0]   add_res;

    // Control
    logic [NUM_STREAMS-1:0]            consume;
    logic [NUM_STREAMS-1:0]            accept;
    logic [NUM_STREAMS-1:0][IDX_W-1:0] dec_idx;
    logic [NUM_STREAMS-1:0]            dec_cry;
    logic                              match;
    logic [IDX_W-1:0]                  max_idx;
    logic                              all_v;
    logic                              any_done;
    logic                              all_done;
    logic                              out_accept;

    // Absolute index of an incoming token; MSB of the result is the carry
    // out of IDX_W bits.
    function automatic logic [IDX_W:0] decode_idx(input logic             first,
                                                  input logic [IDX_W-1:0] prev,
                                                  input logic [SKIP_W-1:0] skip);
        logic [IDX_W:0] nxt;
        if (first)
            nxt = (IDX_W+1)'(skip);
        else
            nxt = {1'b0, prev} + (IDX_W+1)'(skip) + (IDX_W+1)'(1);
        return nxt;
    endfunction

    // Accumulate one product. MSB of the result flags overflow; the low
    // ACCUM_W bits are the clamped or wrapped sum.
    function automatic logic [ACCUM_W:0] acc_add(input logic [ACCUM_W-1:0] a,
                                                 input logic [PROD_W-1:0]  p);
        logic [SUM_W-1:0] sum;
        logic [ACCUM_W:0] res;
        sum = SUM_W'(a) + SUM_W'(p);
        if (sum > SUM_W'({ACCUM_W{1'b1}})) begin
            if (SATURATE != 0)
                res = {1'b1, {ACCUM_W{1'b1}}};
            else
                res = {1'b1, sum[ACCUM_W-1:0]};
        end else begin
            res = {1'b0, sum[ACCUM_W-1:0]};
        end
        return res;
    endfunction

    assign out_accept = (state_q == ST_OUT) && mac_ready_i;

    // Intersection: find the largest head index, detect a full match and
    // pick which heads advance this cycle.
    always_comb begin
        consume  = '0;
        match    = 1'b0;
        max_idx  = '0;
        all_v    = &head_v_q;
        any_done = |(head_v_q & head_done_q);
        all_done = &(head_v_q & head_done_q);
        for (int s = 0; s < NUM_STREAMS; s++) begin
            if (head_v_q[s] && !head_done_q[s] && (head_idx_q[s] > max_idx))
                max_idx = head_idx_q[s];
        end
        if ((state_q == ST_RUN) && all_v && !any_done) begin
            match = 1'b1;
            for (int s = 0; s < NUM_STREAMS; s++) begin
                if (head_idx_q[s] != max_idx)
                    match = 1'b0;
            end
            for (int s = 0; s < NUM_STREAMS; s++)
                consume[s] = match || (head_idx_q[s] < max_idx);
        end else if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && any_done) begin
            consume = head_v_q & ~head_done_q;
        end
    end

    // Token handshake and index decode for every stream.
    always_comb begin
        sram_ready_o = '0;
        dec_idx      = '0;
        dec_cry      = '0;
        if (state_q != ST_OUT)
            sram_ready_o = ~head_v_q | consume;
        accept = sram_valid_i & sram_ready_o;
        for (int s = 0; s < NUM_STREAMS; s++)
            {dec_cry[s], dec_idx[s]} = decode_idx(first_q[s], head_idx_q[s],
                                                  sram_skip_i[s*SKIP_W +: SKIP_W]);
    end

    // Load accepted tokens into heads, retire consumed heads, clear per vector.
    always_ff @(posedge mac_clk) begin
        if (mac_rst || out_accept) begin
            head_v_q    <= '0;
            head_done_q <= '0;
            first_q     <= '1;
        end else begin
            for (int s = 0; s < NUM_STREAMS; s++) begin
                if (accept[s]) begin
                    head_v_q[s]    <= 1'b1;
                    head_done_q[s] <= sram_done_i[s];
                    if (!sram_done_i[s]) begin
                        head_idx_q[s] <= dec_idx[s];
                        head_val_q[s] <= sram_value_i[s*VALUE_W +: VALUE_W];
                        first_q[s]    <= 1'b0;
                    end
                end else if (consume[s]) begin
                    head_v_q[s] <= 1'b0;
                end
            end
        end
    end

    // Product of all head values at a common index.
    always_comb begin
        prod_c = PROD_W'(head_val_q[0]);
        for (int s = 1; s < NUM_STREAMS; s++)
            prod_c = prod_c * PROD_W'(head_val_q[s]);
    end

    // Product stage register; reset only drops the valid so an in-flight
    // product is discarded.
    always_ff @(posedge mac_clk) begin
        if (mac_rst)
            vld_p1_q <= 1'b0;
        else
            vld_p1_q <= match;
        prod_p1_q <= prod_c;
    end

    assign add_res = acc_add(accum_q, prod_p1_q);

    // Next accumulator, sticky overflow and match count.
    always_comb begin
        accum_d = accum_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (vld_p1_q) begin
            accum_d = add_res[ACCUM_W-1:0];
            ovf_d   = ovf_q | add_res[ACCUM_W];
        end
        if (|(accept & ~sram_done_i & dec_cry))
            ovf_d = 1'b1;
        if (match)
            cnt_d = cnt_q + IDX_W'(1);
        if (out_accept) begin
            accum_d = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    // Accumulation state registers.
    always_ff @(posedge mac_clk) begin
        if (mac_rst) begin
            accum_q <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            accum_q <= accum_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Vector sequencing: gather, drain after a done marker, let the last
    // product retire, then hold the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (all_done)
                    state_d = ST_FLUSH;
                else if (any_done)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (all_done)
                    state_d = ST_FLUSH;
            end
            ST_FLUSH: state_d = ST_OUT;
            ST_OUT: begin
                if (mac_ready_i)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge mac_clk) begin
        if (mac_rst)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // Result port is only populated while the result is being offered.
    always_comb begin
        mac_valid_o     = (state_q == ST_OUT);
        mac_data_o      = '0;
        mac_ovf_o       = 1'b0;
        mac_match_cnt_o = '0;
        if (state_q == ST_OUT) begin
            mac_data_o      = accum_q;
            mac_ovf_o       = ovf_q;
            mac_match_cnt_o = cnt_q;
        end
    end

endmodule

// File: tb/tb_sparse_mac_nway.sv
// Testbench for sparse_mac_nway: four instances cover N=2/32-bit saturate,
// N=3, and 8-bit accumulators in saturate and wrap modes.
module tb_sparse_mac_nway;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   total;
    int   bad;
    bit   feed_en;
    bit   gaps;

    // Pending tokens per instance/stream: {done, skip[7:0], value[7:0]}
    int unsigned tokq [4][3][$];

    logic [3:0] mrdy;
    wire  [3:0] mv;
    wire  [3:0] movf;
    wire  [31:0] mdata [4];
    wire  [15:0] mcnt  [4];
    wire  [2:0]  srdy  [4];

    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int NK  = (k == 1) ? 3 : 2;
        localparam int AW  = (k >= 2) ? 8 : 32;
        localparam int SAT = (k == 3) ? 0 : 1;

        wire [NK-1:0]   v_b;
        wire [NK-1:0]   d_b;
        wire [NK-1:0]   rdy;
        wire [NK*8-1:0] sk_b;
        wire [NK*8-1:0] vl_b;
        wire [AW-1:0]   dat;
        wire [15:0]     cnt;
        wire            vo;
        wire            ovf;

        sparse_mac_nway #(
            .NUM_STREAMS(NK), .VALUE_W(8), .SKIP_W(8), .IDX_W(16),
            .ACCUM_W(AW), .SATURATE(SAT)
        ) u_dut (
            .mac_clk        (clk),
            .mac_rst        (rst),
            .sram_valid_i   (v_b),
            .sram_ready_o   (rdy),
            .sram_done_i    (d_b),
            .sram_skip_i    (sk_b),
            .sram_value_i   (vl_b),
            .mac_valid_o    (vo),
            .mac_ready_i    (mrdy[k]),
            .mac_data_o     (dat),
            .mac_ovf_o      (ovf),
            .mac_match_cnt_o(cnt)
        );

        assign mv[k]    = vo;
        assign movf[k]  = ovf;
        assign mdata[k] = 32'(dat);
        assign mcnt[k]  = cnt;
        assign srdy[k]  = 3'(rdy);

        for (genvar s = 0; s < NK; s++) begin : g_s
            logic       v;
            logic       dn;
            logic [7:0] sk;
            logic [7:0] vl;

            assign v_b[s]         = v;
            assign d_b[s]         = dn;
            assign sk_b[s*8 +: 8] = sk;
            assign vl_b[s*8 +: 8] = vl;

            // Token source with random idle gaps; pops a token once handshaked.
            initial begin
                bit          cur;
                bit          rl;
                int unsigned tok;
                cur = 1'b0; rl = 1'b0; tok = 0;
                v = 1'b0; dn = 1'b0; sk = '0; vl = '0;
                forever begin
                    @(negedge clk);
                    if (cur && rl && tokq[k][s].size() > 0)
                        void'(tokq[k][s].pop_front());
                    cur = 1'b0;
                    if (feed_en && tokq[k][s].size() > 0 &&
                        (!gaps || $urandom_range(0, 3) != 0)) begin
                        cur = 1'b1;
                        tok = tokq[k][s][0];
                    end
                    v  = cur;
                    dn = tok[16];
                    sk = tok[15:8];
                    vl = tok[7:0];
                    #1 rl = rdy[s];
                end
            end
        end
    end

    task automatic push(input int k, input int s, input int dn, input int sk, input int vl);
        tokq[k][s].push_back($unsigned(((dn & 1) << 16) | ((sk & 255) << 8) | (vl & 255)));
    endtask

    task automatic wait_valid(input int k, output bit ok);
        int n;
        n = 0;
        while (!mv[k] && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        ok = mv[k];
    endtask

    task automatic accept(input int k);
        mrdy[k] = 1'b1;
        @(posedge clk); #2;
        mrdy[k] = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mv[k] !== 1'b0 || mdata[k] !== 32'd0 || mcnt[k] !== 16'd0 || movf[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs inst=%0d got v=%b d=%0d c=%0d o=%b want all 0",
                         k, mv[k], mdata[k], mcnt[k], movf[k]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #2;
        total++;
        if (srdy[0] !== 3'b011) begin
            bad++;
            $display("FAIL reset_ready got=%b want=011", srdy[0]);
        end
        total++;
        if (mv !== 4'b0000) begin
            bad++;
            $display("FAIL reset_valid got=%b want=0000", mv);
        end
    endtask

    task automatic test_t1();
        bit ok;
        push(0, 0, 0, 0, 2); push(0, 0, 0, 0, 3); push(0, 0, 0, 0, 4); push(0, 0, 1, 0, 0);
        push(0, 1, 0, 1, 5); push(0, 1, 1, 0, 0);
        wait_valid(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL t1_timeout got=0 want=1"); end
        total++; if (mdata[0] !== 32'd15) begin bad++; $display("FAIL t1_data got=%0d want=15", mdata[0]); end
        total++; if (mcnt[0] !== 16'd1) begin bad++; $display("FAIL t1_cnt got=%0d want=1", mcnt[0]); end
        total++; if (movf[0] !== 1'b0) begin bad++; $display("FAIL t1_ovf got=%b want=0", movf[0]); end
        accept(0);
        total++; if (mv[0] !== 1'b0) begin bad++; $display("FAIL t1_valid_drop got=%b want=0", mv[0]); end
    endtask

    task automatic test_t2();
        bit ok;
        for (int s = 0; s < 3; s++) begin
            for (int i = 1; i <= 4; i++) push(1, s, 0, 0, i);
            push(1, s, 1, 0, 0);
        end
        wait_valid(1, ok);
        total++; if (!ok) begin bad++; $display("FAIL t2_timeout got=0 want=1"); end
        total++; if (mdata[1] !== 32'd100) begin bad++; $display("FAIL t2_data got=%0d want=100", mdata[1]); end
        total++; if (mcnt[1] !== 16'd4) begin bad++; $display("FAIL t2_cnt got=%0d want=4", mcnt[1]); end
        total++; if (movf[1] !== 1'b0) begin bad++; $display("FAIL t2_ovf got=%b want=0", movf[1]); end
        accept(1);
    endtask

    task automatic test_t3();
        bit ok;
        for (int k = 2; k < 4; k++) begin
            push(k, 0, 0, 0, 20); push(k, 0, 0, 0, 10); push(k, 0, 1, 0, 0);
            push(k, 1, 0, 0, 10); push(k, 1, 0, 0, 10); push(k, 1, 1, 0, 0);
        end
        wait_valid(2, ok);
        total++; if (!ok) begin bad++; $display("FAIL t3_sat_timeout got=0 want=1"); end
        total++; if (mdata[2] !== 32'd255) begin bad++; $display("FAIL t3_sat_data got=%0d want=255", mdata[2]); end
        total++; if (movf[2] !== 1'b1) begin bad++; $display("FAIL t3_sat_ovf got=%b want=1", movf[2]); end
        total++; if (mcnt[2] !== 16'd2) begin bad++; $display("FAIL t3_sat_cnt got=%0d want=2", mcnt[2]); end
        wait_valid(3, ok);
        total++; if (!ok) begin bad++; $display("FAIL t3_wrap_timeout got=0 want=1"); end
        total++; if (mdata[3] !== 32'd44) begin bad++; $display("FAIL t3_wrap_data got=%0d want=44", mdata[3]); end
        total++; if (movf[3] !== 1'b1) begin bad++; $display("FAIL t3_wrap_ovf got=%b want=1", movf[3]); end
        accept(2);
        accept(3);
    endtask

    task automatic test_back_to_back();
        bit ok;
        push(0, 0, 0, 5, 7); push(0, 0, 1, 0, 0);
        push(0, 1, 0, 5, 6); push(0, 1, 1, 0, 0);
        push(0, 0, 0, 0, 3); push(0, 0, 1, 0, 0);
        push(0, 1, 0, 0, 3); push(0, 1, 1, 0, 0);
        wait_valid(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL t4_timeout got=0 want=1"); end
        for (int c = 0; c < 10; c++) begin
            total++; if (mv[0] !== 1'b1) begin bad++; $display("FAIL t4_hold_valid cyc=%0d got=%b want=1", c, mv[0]); end
            total++; if (mdata[0] !== 32'd42) begin bad++; $display("FAIL t4_hold_data cyc=%0d got=%0d want=42", c, mdata[0]); end
            total++; if (srdy[0] !== 3'b000) begin bad++; $display("FAIL t4_hold_ready cyc=%0d got=%b want=000", c, srdy[0]); end
            @(posedge clk); #2;
        end
        accept(0);
        wait_valid(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL t4_next_timeout got=0 want=1"); end
        total++; if (mdata[0] !== 32'd9) begin bad++; $display("FAIL t4_next_data got=%0d want=9", mdata[0]); end
        total++; if (mcnt[0] !== 16'd1) begin bad++; $display("FAIL t4_next_cnt got=%0d want=1", mcnt[0]); end
        accept(0);
    endtask

    task automatic test_empty();
        bit ok;
        push(0, 1, 1, 0, 0);
        for (int i = 0; i < 50; i++) push(0, 0, 0, $urandom_range(0, 3), $urandom_range(1, 255));
        push(0, 0, 1, 0, 0);
        wait_valid(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL t5_timeout got=0 want=1"); end
        total++; if (mdata[0] !== 32'd0) begin bad++; $display("FAIL t5_data got=%0d want=0", mdata[0]); end
        total++; if (mcnt[0] !== 16'd0) begin bad++; $display("FAIL t5_cnt got=%0d want=0", mcnt[0]); end
        total++; if (tokq[0][0].size() != 0) begin bad++; $display("FAIL t5_drained left=%0d want=0", tokq[0][0].size()); end
        accept(0);
    endtask

    task automatic test_abort();
        bit ok;
        for (int i = 1; i <= 6; i++) begin
            push(0, 0, 0, 0, i);
            push(0, 1, 0, 0, i);
        end
        repeat (4) begin @(posedge clk); #2; end
        feed_en = 1'b0;
        tokq[0][0].delete();
        tokq[0][1].delete();
        rst = 1'b1;
        @(posedge clk); #2;
        total++;
        if (mv[0] !== 1'b0 || mdata[0] !== 32'd0 || mcnt[0] !== 16'd0 || movf[0] !== 1'b0) begin
            bad++;
            $display("FAIL t6_abort got v=%b d=%0d c=%0d o=%b want all 0", mv[0], mdata[0], mcnt[0], movf[0]);
        end
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #2;
            total++; if (mv[0] !== 1'b0) begin bad++; $display("FAIL t6_no_result got=%b want=0", mv[0]); end
        end
        feed_en = 1'b1;
        push(0, 0, 0, 0, 2); push(0, 0, 0, 0, 3); push(0, 0, 0, 0, 4); push(0, 0, 1, 0, 0);
        push(0, 1, 0, 1, 5); push(0, 1, 1, 0, 0);
        wait_valid(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL t6_timeout got=0 want=1"); end
        total++; if (mdata[0] !== 32'd15) begin bad++; $display("FAIL t6_data got=%0d want=15", mdata[0]); end
        total++; if (mcnt[0] !== 16'd1) begin bad++; $display("FAIL t6_cnt got=%0d want=1", mcnt[0]); end
        accept(0);
    endtask

    // Random correlated vector checked against a set-intersection model.
    task automatic test_random(input int k, input int nidx);
        int     n, sat, cnt, last;
        longint acc, maxv, p;
        bit     ovf, ok, hot, all;
        bit     pres [3][256];
        int     vals [3][256];
        n    = (k == 1) ? 3 : 2;
        sat  = (k == 3) ? 0 : 1;
        maxv = (k >= 2) ? 64'd255 : 64'hFFFF_FFFF;
        for (int i = 0; i < nidx; i++) begin
            hot = ($urandom_range(0, 99) < 35);
            for (int s = 0; s < n; s++) begin
                pres[s][i] = hot || ($urandom_range(0, 1) == 1);
                vals[s][i] = $urandom_range(1, 255);
            end
        end
        for (int s = 0; s < n; s++) begin
            last = -1;
            for (int i = 0; i < nidx; i++) begin
                if (pres[s][i]) begin
                    push(k, s, 0, (last < 0) ? i : i - last - 1, vals[s][i]);
                    last = i;
                end
            end
            push(k, s, 1, 0, 0);
        end
        acc = 0; ovf = 1'b0; cnt = 0;
        for (int i = 0; i < nidx; i++) begin
            all = 1'b1;
            p = 1;
            for (int s = 0; s < n; s++) begin
                if (!pres[s][i]) all = 1'b0;
                p = p * vals[s][i];
            end
            if (all) begin
                cnt++;
                acc = acc + p;
                if (acc > maxv) begin
                    ovf = 1'b1;
                    acc = (sat != 0) ? maxv : (acc & maxv);
                end
            end
        end
        wait_valid(k, ok);
        total++; if (!ok) begin bad++; $display("FAIL rand_timeout inst=%0d got=0 want=1", k); end
        total++; if (mdata[k] !== 32'(acc)) begin bad++; $display("FAIL rand_data inst=%0d got=%0d want=%0d", k, mdata[k], acc); end
        total++; if (mcnt[k] !== 16'(cnt)) begin bad++; $display("FAIL rand_cnt inst=%0d got=%0d want=%0d", k, mcnt[k], cnt); end
        total++; if (movf[k] !== ovf) begin bad++; $display("FAIL rand_ovf inst=%0d got=%b want=%b", k, movf[k], ovf); end
        accept(k);
        total++; if (mv[k] !== 1'b0) begin bad++; $display("FAIL rand_valid_drop inst=%0d got=%b want=0", k, mv[k]); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        mrdy    = 4'b0000;
        feed_en = 1'b1;
        gaps    = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        test_reset();
        test_t1();
        test_t2();
        test_t3();
        test_back_to_back();
        test_empty();
        test_abort();
        for (int v = 0; v < 4; v++) test_random(0, 60);
        for (int v = 0; v < 2; v++) test_random(1, 50);
        for (int v = 0; v < 2; v++) test_random(3, 40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
